// File: rtl/pin_bridge.sv
// Registered pin router: synchronised, glitch-filtered inputs routed to outputs
// through a writable route table, with per-output mode and rising-edge counters.
module pin_bridge #(
    parameter int N_IN        = 8,
    parameter int N_OUT       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4,
    parameter int CNT_W       = 16,
    localparam int SW         = $clog2(N_IN),
    localparam int AW         = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   pin_in,
    output logic [N_OUT-1:0]  pin_out,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [SW+1:0]     cfg_wdata,
    input  logic              cnt_clr,
    input  logic [AW-1:0]     rd_addr,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int NSEL = 2 ** SW;
    // Marks which select codes name a real input; all others route to constant 0.
    localparam logic [NSEL-1:0] SEL_MASK = {NSEL{1'b1}} >> (NSEL - N_IN);

    logic [N_IN-1:0]   sync_r [SYNC_STAGES];
    logic [N_IN-1:0]   filt_r;
    logic [FILT_W-1:0] fcnt_r [N_IN];
    logic [SW-1:0]     sel_r  [N_OUT];
    logic [1:0]        mode_r [N_OUT];
    logic [N_OUT-1:0]  pout_r;
    logic [CNT_W-1:0]  cnt_r  [N_OUT];

    logic [N_IN-1:0]   sync_last_s;
    logic [NSEL-1:0]   f_pad_s;
    logic [N_OUT-1:0]  out_next_s;

    assign sync_last_s = sync_r[SYNC_STAGES-1];
    assign f_pad_s     = NSEL'(filt_r);
    assign pin_out     = pout_r;

    // Synchroniser chains for the raw asynchronous pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
        end else begin
            sync_r[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    // Glitch filter: accept a new level once it has persisted past filt_len.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r <= '0;
            for (int i = 0; i < N_IN; i++) begin
                fcnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_last_s[i] == filt_r[i]) begin
                    fcnt_r[i] <= '0;
                end else if (fcnt_r[i] == filt_len) begin
                    filt_r[i] <= sync_last_s[i];
                    fcnt_r[i] <= '0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + FILT_W'(1);
                end
            end
        end
    end

    // Route table; out-of-range addresses match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                sel_r[j]  <= SW'(j % N_IN);
                mode_r[j] <= 2'b00;
            end
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                if (cfg_we && (cfg_addr == AW'(j))) begin
                    sel_r[j]  <= cfg_wdata[SW-1:0];
                    mode_r[j] <= cfg_wdata[SW+1:SW];
                end else begin
                    sel_r[j]  <= sel_r[j];
                    mode_r[j] <= mode_r[j];
                end
            end
        end
    end

    // Next output value per channel from its route entry.
    always_comb begin
        out_next_s = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (SEL_MASK[sel_r[j]]) begin
                case (mode_r[j])
                    2'b00:   out_next_s[j] = f_pad_s[sel_r[j]];
                    2'b01:   out_next_s[j] = ~f_pad_s[sel_r[j]];
                    2'b10:   out_next_s[j] = 1'b0;
                    2'b11:   out_next_s[j] = 1'b1;
                    default: out_next_s[j] = 1'b0;
                endcase
            end else begin
                out_next_s[j] = 1'b0;
            end
        end
    end

    // Output register plus saturating rising-edge counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout_r <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                cnt_r[j] <= '0;
            end
        end else begin
            pout_r <= out_next_s;
            for (int j = 0; j < N_OUT; j++) begin
                if (cnt_clr) begin
                    cnt_r[j] <= '0;
                end else if (!pout_r[j] && out_next_s[j] && (cnt_r[j] != {CNT_W{1'b1}})) begin
                    cnt_r[j] <= cnt_r[j] + CNT_W'(1);
                end else begin
                    cnt_r[j] <= cnt_r[j];
                end
            end
        end
    end

    // Counter readback mux; addresses beyond the table read as 0.
    always_comb begin
        rd_cnt = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (rd_addr == AW'(j)) begin
                rd_cnt = cnt_r[j];
            end else begin
                rd_cnt = rd_cnt;
            end
        end
    end

endmodule

// File: tb/tb_pin_bridge.sv
// Directed bench for pin_bridge: cycle-by-cycle model comparison on a default
// instance plus literal checks on a small (6-in, 6-out, 4-bit counter) instance.
module tb_pin_bridge;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_in;
    logic [7:0] pin_out;
    logic [3:0] filt_len;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [4:0] cfg_wdata;
    logic       cnt_clr;
    logic [2:0] rd_addr;
    logic [15:0] rd_cnt;

    logic [5:0] s_pin_in;
    logic [5:0] s_pin_out;
    logic [3:0] s_filt_len;
    logic       s_cfg_we;
    logic [2:0] s_cfg_addr;
    logic [4:0] s_cfg_wdata;
    logic       s_cnt_clr;
    logic [2:0] s_rd_addr;
    logic [3:0] s_rd_cnt;

    int total = 0;
    int bad   = 0;
    logic chk_en;

    pin_bridge dut (
        .clk(clk), .rst_n(rst_n), .pin_in(pin_in), .pin_out(pin_out),
        .filt_len(filt_len), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cnt_clr(cnt_clr), .rd_addr(rd_addr), .rd_cnt(rd_cnt)
    );

    pin_bridge #(.N_IN(6), .N_OUT(6), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .pin_in(s_pin_in), .pin_out(s_pin_out),
        .filt_len(s_filt_len), .cfg_we(s_cfg_we), .cfg_addr(s_cfg_addr),
        .cfg_wdata(s_cfg_wdata), .cnt_clr(s_cnt_clr), .rd_addr(s_rd_addr), .rd_cnt(s_rd_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the default instance ----------------
    logic [7:0] m_s0, m_s1, m_f, m_out;
    int         m_run [8];
    int         m_sel [8];
    logic [1:0] m_mode [8];
    int         m_cnt [8];

    function automatic logic route_val(input int sel, input logic [1:0] mode, input logic [7:0] f);
        if (sel >= 8) return 1'b0;
        case (mode)
            2'b00:   return f[sel];
            2'b01:   return ~f[sel];
            2'b10:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s0 <= '0; m_s1 <= '0; m_f <= '0; m_out <= '0;
            for (int i = 0; i < 8; i++) begin
                m_run[i] <= 0; m_sel[i] <= i; m_mode[i] <= 2'b00; m_cnt[i] <= 0;
            end
        end else begin
            m_s0 <= pin_in;
            m_s1 <= m_s0;
            for (int i = 0; i < 8; i++) begin
                if (m_s1[i] == m_f[i]) m_run[i] <= 0;
                else if (m_run[i] == int'(filt_len)) begin
                    m_f[i] <= m_s1[i];
                    m_run[i] <= 0;
                end else m_run[i] <= (m_run[i] + 1) % 16;
            end
            for (int j = 0; j < 8; j++) begin
                m_out[j] <= route_val(m_sel[j], m_mode[j], m_f);
                if (cnt_clr) m_cnt[j] <= 0;
                else if (!m_out[j] && route_val(m_sel[j], m_mode[j], m_f) && m_cnt[j] < 65535)
                    m_cnt[j] <= m_cnt[j] + 1;
            end
            if (cfg_we) begin
                m_sel[cfg_addr]  <= int'(cfg_wdata[2:0]);
                m_mode[cfg_addr] <= cfg_wdata[4:3];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            check("model_pin_out", pin_out, m_out);
            check("model_rd_cnt", rd_cnt, m_cnt[rd_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [4:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cyc(1);
        cfg_we = 1'b0;
    endtask

    task automatic write_small(input logic [2:0] a, input logic [4:0] d);
        s_cfg_we = 1'b1; s_cfg_addr = a; s_cfg_wdata = d;
        cyc(1);
        s_cfg_we = 1'b0;
    endtask

    task automatic pulses0(input int n);
        repeat (n) begin
            pin_in[0] = 1'b1; cyc(2);
            pin_in[0] = 1'b0; cyc(2);
        end
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; chk_en = 1'b0;
        pin_in = '0; filt_len = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        cnt_clr = 1'b0; rd_addr = '0;
        s_pin_in = '0; s_filt_len = '0; s_cfg_we = 1'b0; s_cfg_addr = '0; s_cfg_wdata = '0;
        s_cnt_clr = 1'b0; s_rd_addr = '0;
        cyc(3);
        check("rst_pin_out", pin_out, 32'h0);
        check("rst_rd_cnt", rd_cnt, 32'h0);
        check("rst_small_out", s_pin_out, 32'h0);
        rst_n = 1'b1; chk_en = 1'b1;
        cyc(2);

        // pin-to-pin latency with L=0
        pin_in = 8'hA5;
        cyc(3);
        check("lat_edge3", pin_out, 32'h00);
        cyc(1);
        check("lat_edge4", pin_out, 32'hA5);
        check("lat_edge4_model", m_out, 32'hA5);
        check("lat_cnt_ch0", rd_cnt, 32'd1);

        // glitch filter, L=3: a 3-cycle pulse is rejected
        pin_in = '0; cyc(8);
        filt_len = 4'd3; cyc(2);
        pin_in[2] = 1'b1; cyc(3); pin_in[2] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cyc(1);
            seen = seen | pin_out[2];
        end
        check("glitch_reject", seen, 32'h0);

        // 5-cycle pulse: out high on edges 7..11 after onset
        pin_in[2] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            cyc(1);
            if (n == 5) pin_in[2] = 1'b0;
            check($sformatf("pulse5_edge%0d", n), pin_out[2], (n >= 7 && n <= 11) ? 32'h1 : 32'h0);
        end
        filt_len = 4'd0; cyc(4);

        // routing and modes
        pin_in = 8'h40; cyc(6);
        write_cfg(3'd1, {2'b01, 3'd6});
        write_cfg(3'd4, {2'b11, 3'd0});
        write_cfg(3'd5, {2'b00, 3'd7});
        cyc(1);
        check("route_vec", pin_out, 32'h50);
        check("route_ch4", pin_out[4], 32'h1);

        // counter: 10 rising edges
        pin_in = '0; cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        pulses0(10);
        cyc(6);
        check("toggle10", rd_cnt, 32'd10);

        // clear coincident with a rising edge
        pin_in[0] = 1'b1; cyc(3);
        cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        check("clr_rise_out", pin_out[0], 32'h1);
        check("clr_rise_cnt", rd_cnt, 32'd0);
        cyc(3);
        check("clr_hold", rd_cnt, 32'd0);

        // small instance: saturation, out-of-range reads/writes/selects
        for (int n = 0; n < 20; n++) begin
            s_pin_in[0] = 1'b1; cyc(2);
            s_pin_in[0] = 1'b0; cyc(2);
        end
        cyc(6);
        check("sat15", s_rd_cnt, 32'd15);
        s_rd_addr = 3'd7; #1;
        check("rd_oor7", s_rd_cnt, 32'd0);
        s_rd_addr = 3'd6; #1;
        check("rd_oor6", s_rd_cnt, 32'd0);
        s_rd_addr = 3'd0;
        write_small(3'd6, {2'b11, 3'd0});
        write_small(3'd7, {2'b11, 3'd1});
        cyc(2);
        check("wr_oor", s_pin_out, 32'h00);
        write_small(3'd2, {2'b11, 3'd7});
        write_small(3'd3, {2'b11, 3'd6});
        write_small(3'd0, {2'b11, 3'd5});
        cyc(2);
        check("sel_oor", s_pin_out, 32'h01);

        // asynchronous reset mid-run with counters at 5 and modified table
        pin_in = '0; cyc(6);
        cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
        pulses0(5);
        cyc(6);
        check("cnt5", rd_cnt, 32'd5);
        check("pre_rst_ch4", pin_out[4], 32'h1);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_out", pin_out, 32'h0);
        check("arst_cnt", rd_cnt, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        pin_in = 8'h3C; cyc(6);
        check("post_rst_identity", pin_out, 32'h3C);
        rd_addr = 3'd2; #1;
        check("post_rst_cnt2", rd_cnt, 32'd1);
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
